modulation_stage_buffer: RTL and testbench
==========================================

// Module: modulation_stage_buffer
// PURPOSE
//  Double-buffered duty/phase store between the per-frame modulation calculator and the PWM stage.
//  The calculator streams DEPTH (duty, phase) pairs serially into a shadow bank; a DONE strobe then
//  commits the whole bank atomically to the parallel outputs.
//  Adds frame-completeness checking, a HOLD freeze, and an optional one-frame phase lag.
// PARAMETERS
//  WIDTH        13   bit width of each duty and phase word
//  DEPTH        249  number of transducer channels
//  PHASE_DELAY  1    1: committed phase is the previous frame's phase; 0: same-frame phase
//  IDX_W        $clog2(DEPTH)  channel index width (localparam; not overridable)
// PORTS
//  CLK        in   1                  system clock; all logic on posedge
//  RST        in   1                  synchronous, active-high reset
//  START      in   1                  begin loading a new frame
//  DIN_VALID  in   1                  DIN_IDX/DUTY_IN/PHASE_IN valid this cycle
//  DIN_IDX    in   IDX_W              channel index of the incoming pair
//  DUTY_IN    in   WIDTH              duty word
//  PHASE_IN   in   WIDTH              phase word
//  DONE       in   1                  commit request
//  HOLD       in   1                  freeze outputs; a commit accepted while HOLD=1 stays pending
//  CLR_ERR    in   1                  clears FRAME_ERR
//  DUTY_OUT   out  WIDTH x [0:DEPTH-1]  active duty bank
//  PHASE_OUT  out  WIDTH x [0:DEPTH-1]  active phase bank
//  BUSY       out  1                  high in LOAD
//  COMMIT     out  1                  one-cycle pulse, same cycle the active bank changes
//  FRAME_ERR  out  1                  sticky error flag
// BEHAVIOUR
//  Reset (RST=1 at posedge)
//   - state=IDLE; ptr=0; pending=0.
//   - DUTY_OUT, PHASE_OUT and phase-lag bank all zero.
//   - BUSY=0, COMMIT=0, FRAME_ERR=0.
//   - Shadow contents are don't-care. Reset mid-LOAD discards the partial frame.
//  States
//   - IDLE : START -> LOAD, ptr=0.
//   - LOAD : DIN_VALID with DIN_IDX==ptr writes shadow[ptr] and increments ptr.
//            On the write with ptr==DEPTH-1 -> READY.
//            DIN_VALID with DIN_IDX!=ptr: word dropped, FRAME_ERR<=1, ptr unchanged.
//   - READY: DONE with HOLD=0 -> commit -> IDLE. DONE with HOLD=1 -> pending=1, stay READY.
//            pending with HOLD=0 -> commit, pending=0 -> IDLE.
//  Commit
//   - DONE (or pending release) sampled at posedge n; DUTY_OUT/PHASE_OUT update at n+1; COMMIT=1 during n+1.
//   - PHASE_DELAY=1: PHASE_OUT<=lag bank, and lag bank<=shadow phase, in the same edge.
//   - PHASE_DELAY=0: PHASE_OUT<=shadow phase.
//  Boundary conditions
//   - DONE in IDLE or LOAD: FRAME_ERR<=1, no commit, outputs unchanged.
//   - START in LOAD: restart, ptr=0, no error.
//   - START in READY with pending=1: FRAME_ERR<=1, pending dropped.
//   - START and DONE in the same READY cycle with HOLD=0: commit happens AND next state is LOAD.
//   - DIN_VALID in the START cycle: ignored.
//   - DIN_VALID in IDLE or READY: ignored, no error.
//   - CLR_ERR and an error event in the same cycle: the error wins.
//   - DIN_IDX>=DEPTH: treated as a mismatch.
//   - No arithmetic on data; words pass through unmodified.
//   - ptr saturates at DEPTH-1; it never wraps.
// STRUCTURE
//  Package modulation_stage_buffer_pkg:
//   - typedef enum logic [1:0] {IDLE, LOAD, READY} stage_state_t.
//  Sub-module modulation_stage_ctrl:
//   - owns the FSM, ptr, pending and FRAME_ERR.
//   - emits wr_en/wr_idx and commit_en.
//  The top holds the shadow, lag and active banks (DEPTH-wide generate) and the datapath only.
// TESTING
//  1 Reset, full load 0..248 (duty=i, phase=i+1), DONE -> COMMIT at n+1; DUTY_OUT[i]=i.
//    PHASE_OUT=0 (PHASE_DELAY=1); a second identical frame gives PHASE_OUT[i]=i+1.
//  2 Load 100 words, DONE -> FRAME_ERR=1, outputs unchanged, no COMMIT.
//    CLR_ERR -> 0; finish frame, DONE -> commit.
//  3 Full load, HOLD=1, DONE -> no change for 10 cycles.
//    HOLD falls at m -> COMMIT and new data at m+1.
//  4 LOAD, send idx 5 when ptr=3 -> FRAME_ERR=1, ptr stays 3; resend 3,4,5.. -> frame completes.
//  5 READY, START+DONE same cycle -> COMMIT next cycle, BUSY=1.
//    RST mid-LOAD -> all outputs 0, IDLE.

Source files
------------

// File: rtl/modulation_stage_buffer_pkg.sv
//==============================================================================
// Module      : modulation_stage_buffer_pkg
// Description : Shared state encoding for the modulation stage buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package modulation_stage_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/modulation_stage_ctrl.sv
//==============================================================================
// Module      : modulation_stage_ctrl
// Description : Frame-load FSM: write pointer, pending commit and sticky error.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module modulation_stage_ctrl
  import modulation_stage_buffer_pkg::*;
#(
  parameter int DEPTH = 249,
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             din_valid_i,
  input  logic [IDX_W-1:0] din_idx_i,
  input  logic             done_i,
  input  logic             hold_i,
  input  logic             clr_err_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic             commit_en_o,
  output logic             commit_o,
  output logic             busy_o,
  output logic             frame_err_o
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DEPTH - 1);

  stage_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic             busy_q, commit_q;
  logic             w_err_event;
  logic             w_release;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pending_d   = pending_q;
    w_err_event = 1'b0;
    wr_en_o     = 1'b0;
    commit_en_o = 1'b0;
    w_release   = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_i) w_err_event = 1'b1;
        if (start_i) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (done_i) w_err_event = 1'b1;
        if (start_i) begin
          ptr_d = '0;
        end else if (din_valid_i) begin
          // Out-of-range indices can never equal ptr, so they fall into the mismatch path.
          if (din_idx_i == ptr_q) begin
            wr_en_o = 1'b1;
            if (ptr_q == C_LAST) state_d = READY;
            else                 ptr_d   = ptr_q + IDX_W'(1);
          end else begin
            w_err_event = 1'b1;
          end
        end
      end
      READY: begin
        w_release   = pending_q && !start_i;
        commit_en_o = !hold_i && (done_i || w_release);
        if (start_i) begin
          if (pending_q) w_err_event = 1'b1;
          pending_d = 1'b0;
          state_d   = LOAD;
          ptr_d     = '0;
        end else if (commit_en_o) begin
          pending_d = 1'b0;
          state_d   = IDLE;
        end else if (done_i) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (w_err_event)    err_d = 1'b1;
    else if (clr_err_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      busy_q    <= (state_d == LOAD);
      commit_q  <= commit_en_o;
    end
  end

  assign wr_idx_o    = ptr_q;
  assign commit_o    = commit_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/modulation_stage_buffer.sv
//==============================================================================
// Module      : modulation_stage_buffer
// Description : Double-buffered duty/phase store with atomic frame commit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module modulation_stage_buffer
  import modulation_stage_buffer_pkg::*;
#(
  parameter int WIDTH       = 13,
  parameter int DEPTH       = 249,
  parameter bit PHASE_DELAY = 1'b1,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   din_valid_i,
  input  logic [IDX_W-1:0]       din_idx_i,
  input  logic [WIDTH-1:0]       duty_in_i,
  input  logic [WIDTH-1:0]       phase_in_i,
  input  logic                   done_i,
  input  logic                   hold_i,
  input  logic                   clr_err_i,
  output logic [DEPTH*WIDTH-1:0] duty_out_o,
  output logic [DEPTH*WIDTH-1:0] phase_out_o,
  output logic                   busy_o,
  output logic                   commit_o,
  output logic                   frame_err_o
);

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_commit_en;

  modulation_stage_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .din_valid_i (din_valid_i),
    .din_idx_i   (din_idx_i),
    .done_i      (done_i),
    .hold_i      (hold_i),
    .clr_err_i   (clr_err_i),
    .wr_en_o     (w_wr_en),
    .wr_idx_o    (w_wr_idx),
    .commit_en_o (w_commit_en),
    .commit_o    (commit_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_duty_q, shadow_phase_q;
    logic [WIDTH-1:0] lag_phase_q, act_duty_q, act_phase_q;

    // Shadow bank is not reset: its contents only matter once a full frame is loaded.
    always_ff @(posedge clk_i) begin
      if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
        shadow_duty_q  <= duty_in_i;
        shadow_phase_q <= phase_in_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        act_duty_q  <= '0;
        act_phase_q <= '0;
        lag_phase_q <= '0;
      end else if (w_commit_en) begin
        act_duty_q  <= shadow_duty_q;
        act_phase_q <= PHASE_DELAY ? lag_phase_q : shadow_phase_q;
        lag_phase_q <= shadow_phase_q;
      end
    end

    assign duty_out_o[i*WIDTH +: WIDTH]  = act_duty_q;
    assign phase_out_o[i*WIDTH +: WIDTH] = act_phase_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_modulation_stage_buffer.sv
//==============================================================================
// Module      : tb_modulation_stage_buffer
// Description : Directed self-checking bench for modulation_stage_buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_modulation_stage_buffer;

  localparam int W = 13;
  localparam int D = 249;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           din_valid = 1'b0;
  logic [7:0]     din_idx = '0;
  logic [W-1:0]   duty_in = '0;
  logic [W-1:0]   phase_in = '0;
  logic           done = 1'b0;
  logic           hold = 1'b0;
  logic           clr_err = 1'b0;
  logic [D*W-1:0] duty_out, phase_out;
  logic           busy, commit, frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modulation_stage_buffer #(
    .WIDTH       (W),
    .DEPTH       (D),
    .PHASE_DELAY (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .din_valid_i (din_valid),
    .din_idx_i   (din_idx),
    .duty_in_i   (duty_in),
    .phase_in_i  (phase_in),
    .done_i      (done),
    .hold_i      (hold),
    .clr_err_i   (clr_err),
    .duty_out_o  (duty_out),
    .phase_out_o (phase_out),
    .busy_o      (busy),
    .commit_o    (commit),
    .frame_err_o (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame data sets; set 3 is the all-zero reset image.
  function automatic logic [W-1:0] fd(input int k, input int i);
    case (k)
      0:       return W'(i);
      1:       return W'(2 * i + 7);
      2:       return W'(8191 - i);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] fp(input int k, input int i);
    case (k)
      0:       return W'(i + 1);
      1:       return W'(3 * i);
      2:       return W'(5 * i);
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int k);
    din_valid = 1'b1;
    din_idx   = 8'(i);
    duty_in   = fd(k, i);
    phase_in  = fp(k, i);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic load(input int lo, input int hi, input int k);
    for (int i = lo; i <= hi; i++) send(i, k);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic check_banks(input string tag, input int kd, input int kp);
    for (int i = 0; i < D; i++) begin
      check($sformatf("%s_duty%0d", tag, i), 32'(duty_out[i*W +: W]), 32'(fd(kd, i)));
      check($sformatf("%s_phase%0d", tag, i), 32'(phase_out[i*W +: W]), 32'(fp(kp, i)));
    end
  endtask

  initial begin
    // Reset and first frames
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_commit", 32'(commit), 0);
    check("rst_err", 32'(frame_err), 0);
    check_banks("rst", 3, 3);

    pulse_start();
    check("t1_busy_load", 32'(busy), 1);
    load(0, 248, 0);
    check("t1_busy_ready", 32'(busy), 0);
    pulse_done();
    check("t1_commit", 32'(commit), 1);
    check_banks("t1a", 0, 3);
    tick();
    check("t1_commit_drop", 32'(commit), 0);
    pulse_start();
    load(0, 248, 0);
    pulse_done();
    check("t1b_commit", 32'(commit), 1);
    check_banks("t1b", 0, 0);

    // Early DONE during LOAD
    pulse_start();
    load(0, 99, 1);
    pulse_done();
    check("t2_err", 32'(frame_err), 1);
    check("t2_no_commit", 32'(commit), 0);
    check_banks("t2a", 0, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_err_clr", 32'(frame_err), 0);
    load(100, 248, 1);
    pulse_done();
    check("t2_commit", 32'(commit), 1);
    check_banks("t2b", 1, 0);

    // HOLD defers the commit
    pulse_start();
    load(0, 248, 2);
    hold = 1'b1;
    pulse_done();
    for (int c = 0; c < 10; c++) begin
      check("t3_hold_commit", 32'(commit), 0);
      check("t3_hold_duty10", 32'(duty_out[10*W +: W]), 32'(fd(1, 10)));
      tick();
    end
    hold = 1'b0;
    tick();
    check("t3_release_commit", 32'(commit), 1);
    check_banks("t3", 2, 1);

    // Index mismatch keeps the pointer in place
    pulse_start();
    load(0, 2, 0);
    send(5, 0);
    check("t4_err", 32'(frame_err), 1);
    check("t4_busy_after_miss", 32'(busy), 1);
    load(3, 247, 0);
    check("t4_busy_before_last", 32'(busy), 1);
    send(248, 0);
    check("t4_busy_ready", 32'(busy), 0);
    check("t4_err_sticky", 32'(frame_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_err_clr", 32'(frame_err), 0);
    pulse_done();
    check("t4_commit", 32'(commit), 1);
    check_banks("t4", 0, 2);

    // START+DONE together, then reset mid-load
    pulse_start();
    load(0, 248, 1);
    start = 1'b1;
    done  = 1'b1;
    tick();
    start = 1'b0;
    done  = 1'b0;
    check("t5_commit", 32'(commit), 1);
    check("t5_busy", 32'(busy), 1);
    check_banks("t5a", 1, 0);
    load(0, 49, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_commit", 32'(commit), 0);
    check("t5_rst_err", 32'(frame_err), 0);
    check_banks("t5b", 3, 3);
    pulse_done();
    check("t5_idle_done_err", 32'(frame_err), 1);
    check("t5_idle_done_commit", 32'(commit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
